operand_entry: RTL and testbench
================================

OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of hex digits held (operand width 4*DIGITS).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for each key input (minimum 2).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port digit  input  4  hex digit from switches; sampled on the commit edge, and held stable by the user while a key is pressed.
REQ-006 SHALL have ports digit_key, enter_key, clear_key  input  1 each  asynchronous active-high pushbuttons.
REQ-007 SHALL have port ack  input  1  synchronous consumer acknowledge of a locked operand.
REQ-008 SHALL have port operand  output  4*DIGITS  assembled value; digit [3:0] is the most recently entered digit.
REQ-009 SHALL have port digit_count  output  $clog2(DIGITS+1)  number of digits entered.
REQ-010 SHALL have ports full and valid  output  1 each  full means digit_count==DIGITS; valid means the operand is locked.

Function
REQ-011 SHALL pass each key through SYNC_STAGES flops followed by a rising-edge detector, giving one press pulse per low-to-high transition.
REQ-012 SHALL apply a press to state on the (SYNC_STAGES+1)th rising clk edge after the key is first sampled high (3 cycles at the default).
REQ-013 SHALL implement states EMPTY (count 0), ENTRY (1..DIGITS digits) and LOCKED.
REQ-014 On a digit press in EMPTY or ENTRY with count<DIGITS, SHALL set operand to {operand[4*DIGITS-5:0], digit} and increment count; EMPTY moves to ENTRY.
REQ-015 On a digit press at count==DIGITS, SHALL change nothing: no wrap and no overwrite.
REQ-016 On an enter press in ENTRY, SHALL move to LOCKED and assert valid; an enter press in EMPTY SHALL be ignored.
REQ-017 In LOCKED, SHALL ignore digit and enter presses and hold operand and valid constant.
REQ-018 When ack is high in LOCKED, SHALL on the next edge clear operand, count and valid and move to EMPTY; ack outside LOCKED SHALL be ignored.
REQ-019 On a clear press in any state, SHALL clear operand, count and valid and move to EMPTY on the commit edge.
REQ-020 Simultaneous events SHALL resolve by priority: clear > ack > enter > backspace > digit; lower-priority events in that cycle SHALL be dropped.
REQ-021 SHALL drive operand, digit_count, full and valid directly from registers, with no combinational path from any input.

Reset
REQ-022 While reset is high at a clk edge, SHALL set operand=0, digit_count=0, full=0, valid=0, state=EMPTY, and clear all synchronizer and edge flops to 0.
REQ-023 Reset SHALL override every in-progress press, lock or ack in the same edge.
REQ-024 A key held high across reset release SHALL count as exactly one press, committed SYNC_STAGES+1 edges after release.

Configuration
REQ-025 SHALL compile in a backspace feature only when macro OPERAND_ENTRY_BACKSPACE_EN is defined.
REQ-026 With the macro defined, SHALL add input back_key (1 bit, synchronized like the other keys).
REQ-027 With the macro defined, a back_key press in ENTRY SHALL set operand to {4'h0, operand[4*DIGITS-1:4]} and decrement count; reaching count 0 moves to EMPTY.
REQ-028 With the macro defined, a back_key press SHALL be ignored in EMPTY and in LOCKED.
REQ-029 Without the macro, the back_key port and all its logic SHALL be absent.

Structure
REQ-030 SHALL place the state enumeration (EMPTY, ENTRY, LOCKED) and the default DIGITS and SYNC_STAGES constants in shared package operand_entry_pkg.
REQ-031 SHALL implement synchronizer plus edge detection as sub-module key_edge_sync (parameter SYNC_STAGES; ports clk, reset, key, press), instantiated once per key.

Verification
REQ-032 Press digits 1,2,3,4,5,6,7,8 then enter -> operand=32'h12345678, count=8, full=1, valid=1.
REQ-033 Enter 8 digits then press digit 9 -> operand unchanged, count stays 8, no wrap.
REQ-034 Lock 32'hAB, then drive ack=1 for one cycle -> next edge operand=0, count=0, valid=0, state EMPTY; digit presses before the ack have no effect.
REQ-035 Clear and digit rise on the same cycle with operand 32'h5 -> operand=0, count=0; the digit is dropped.
REQ-036 Assert reset for one cycle mid-entry (operand 32'h123) while digit_key is held -> all outputs 0, then exactly one digit commit 3 cycles after release.
REQ-037 With OPERAND_ENTRY_BACKSPACE_EN defined, enter A,B,C then press back -> operand=32'hAB, count=2; back at count 1 -> operand=0, state EMPTY.

Source files
------------

// File: rtl/operand_entry_pkg.sv
// Shared definitions for the operand entry block: entry states and the
// default operand length and key synchronizer depth.
package operand_entry_pkg;

    // Entry state: EMPTY holds no digits, ENTRY holds 1..DIGITS digits,
    // LOCKED holds a finished operand until the consumer acknowledges it.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ENTRY  = 2'd1,
        LOCKED = 2'd2
    } entry_state_e;

    localparam int DEF_DIGITS      = 8;
    localparam int DEF_SYNC_STAGES = 2;

endpackage : operand_entry_pkg

// File: rtl/operand_entry_key_edge_sync.sv
// Brings one asynchronous pushbutton into the clk domain through a
// SYNC_STAGES-deep flop chain and produces a one-cycle press pulse for each
// low-to-high transition of the synchronized level.
module key_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_d;
    logic                   prev_q;

    // Next values: shift the raw key into the chain, remember the last level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], key};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and edge-detect registers; reset clears them so a key held
    // through reset is seen as a fresh rising edge after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // The pulse depends only on flops, so it is glitch-free and is committed
    // by the consumer on the edge that follows it.
    assign press = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : key_edge_sync

// File: rtl/operand_entry.sv
// Hex operand entry from switches and pushbuttons. Digits shift in from the
// right, enter locks the operand, ack or clear releases it.
// Optional backspace key is compiled in with OPERAND_ENTRY_BACKSPACE_EN.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int DIGITS      = DEF_DIGITS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  digit,
    input  logic                        digit_key,
    input  logic                        enter_key,
    input  logic                        clear_key,
`ifdef OPERAND_ENTRY_BACKSPACE_EN
    input  logic                        back_key,
`endif
    input  logic                        ack,
    output logic [4*DIGITS-1:0]         operand,
    output logic [$clog2(DIGITS+1)-1:0] digit_count,
    output logic                        full,
    output logic                        valid
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    localparam logic [CW-1:0] DIGITS_C = CW'(DIGITS);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    logic digit_press_s;
    logic enter_press_s;
    logic clear_press_s;
`ifdef OPERAND_ENTRY_BACKSPACE_EN
    logic back_press_s;
`endif

    entry_state_e  state_d;
    entry_state_e  state_q;
    logic [W-1:0]  operand_d;
    logic [W-1:0]  operand_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;
    logic          full_d;
    logic          full_q;
    logic          valid_d;
    logic          valid_q;

    key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_digit_sync (
        .clk   (clk),
        .reset (reset),
        .key   (digit_key),
        .press (digit_press_s)
    );

    key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_enter_sync (
        .clk   (clk),
        .reset (reset),
        .key   (enter_key),
        .press (enter_press_s)
    );

    key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clear_sync (
        .clk   (clk),
        .reset (reset),
        .key   (clear_key),
        .press (clear_press_s)
    );

`ifdef OPERAND_ENTRY_BACKSPACE_EN
    key_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_back_sync (
        .clk   (clk),
        .reset (reset),
        .key   (back_key),
        .press (back_press_s)
    );
`endif

    // Next-state logic: one event per cycle, clear > ack > enter > back > digit.
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        count_d   = count_q;
        if (clear_press_s) begin
            state_d   = EMPTY;
            operand_d = {W{1'b0}};
            count_d   = {CW{1'b0}};
        end else if (ack && (state_q == LOCKED)) begin
            state_d   = EMPTY;
            operand_d = {W{1'b0}};
            count_d   = {CW{1'b0}};
        end else if (enter_press_s) begin
            // Only a partially or fully entered operand can be locked.
            case (state_q)
                ENTRY:   state_d = LOCKED;
                default: state_d = state_q;
            endcase
`ifdef OPERAND_ENTRY_BACKSPACE_EN
        end else if (back_press_s) begin
            case (state_q)
                ENTRY: begin
                    operand_d = {4'h0, operand_q[W-1:4]};
                    count_d   = count_q - ONE_C;
                    if (count_q == ONE_C) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ENTRY;
                    end
                end
                default: state_d = state_q;
            endcase
`endif
        end else if (digit_press_s) begin
            // A full operand silently refuses further digits.
            case (state_q)
                EMPTY, ENTRY: begin
                    if (count_q < DIGITS_C) begin
                        operand_d = {operand_q[W-5:0], digit};
                        count_d   = count_q + ONE_C;
                        state_d   = ENTRY;
                    end else begin
                        state_d   = state_q;
                    end
                end
                default: state_d = state_q;
            endcase
        end else begin
            state_d = state_q;
        end
        full_d  = (count_d == DIGITS_C);
        valid_d = (state_d == LOCKED);
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            operand_q <= {W{1'b0}};
            count_q   <= {CW{1'b0}};
            full_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            count_q   <= count_d;
            full_q    <= full_d;
            valid_q   <= valid_d;
        end
    end

    assign operand     = operand_q;
    assign digit_count = count_q;
    assign full        = full_q;
    assign valid       = valid_q;

endmodule : operand_entry

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry at default parameters. Stimulus pushes
// the expected output snapshot and the cycle it must appear on; a monitor
// compares on every change of the outputs and flags late or stray updates.
module tb_operand_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  digit;
    logic        digit_key;
    logic        enter_key;
    logic        clear_key;
`ifdef OPERAND_ENTRY_BACKSPACE_EN
    logic        back_key;
`endif
    logic        ack;
    logic [31:0] operand;
    logic [3:0]  digit_count;
    logic        full;
    logic        valid;

    typedef struct {
        int          cyc;
        logic [31:0] op;
        logic [3:0]  cnt;
        logic        fl;
        logic        vl;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    bit          mon_en = 1'b0;
    logic [37:0] prev;
    logic [37:0] cur;

    logic [31:0] seq_op [8] = '{32'h1, 32'h12, 32'h123, 32'h1234,
                                32'h12345, 32'h123456, 32'h1234567, 32'h12345678};

    operand_entry dut (
        .clk         (clk),
        .reset       (reset),
        .digit       (digit),
        .digit_key   (digit_key),
        .enter_key   (enter_key),
        .clear_key   (clear_key),
`ifdef OPERAND_ENTRY_BACKSPACE_EN
        .back_key    (back_key),
`endif
        .ack         (ack),
        .operand     (operand),
        .digit_count (digit_count),
        .full        (full),
        .valid       (valid)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Rising-edge counter used to time expected updates.
    always @(posedge clk) cyc <= cyc + 1;

    assign cur = {operand, digit_count, full, valid};

    // Monitor: compare each output change against the scoreboard head.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev = cur;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                n_vec++;
                n_fail++;
                $display("FAIL missed_update: no change by cycle %0d, required operand=%h count=%0d full=%b valid=%b",
                         mon_e.cyc, mon_e.op, mon_e.cnt, mon_e.fl, mon_e.vl);
            end
            if (cur !== prev) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stray_update at cycle %0d: operand=%h count=%0d full=%b valid=%b, required no change",
                             cyc, operand, digit_count, full, valid);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || operand !== mon_e.op || digit_count !== mon_e.cnt ||
                        full !== mon_e.fl || valid !== mon_e.vl) begin
                        n_fail++;
                        $display("FAIL update: got cycle %0d operand=%h count=%0d full=%b valid=%b, required cycle %0d operand=%h count=%0d full=%b valid=%b",
                                 cyc, operand, digit_count, full, valid,
                                 mon_e.cyc, mon_e.op, mon_e.cnt, mon_e.fl, mon_e.vl);
                    end
                end
            end
            prev = cur;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // mask bit 0 digit, 1 enter, 2 clear, 3 back; commit is 3 edges later.
    task automatic press(input logic [3:0] mask, input logic [3:0] d, input bit chg,
                         input logic [31:0] op, input logic [3:0] cnt,
                         input logic fl, input logic vl);
        @(negedge clk);
        digit     = d;
        digit_key = mask[0];
        enter_key = mask[1];
        clear_key = mask[2];
`ifdef OPERAND_ENTRY_BACKSPACE_EN
        back_key  = mask[3];
`endif
        if (chg) exp_q.push_back('{cyc + 3, op, cnt, fl, vl});
        repeat (6) @(negedge clk);
        digit_key = 1'b0;
        enter_key = 1'b0;
        clear_key = 1'b0;
`ifdef OPERAND_ENTRY_BACKSPACE_EN
        back_key  = 1'b0;
`endif
        repeat (4) @(negedge clk);
    endtask

    // One-cycle ack; a clearing ack shows on the next edge.
    task automatic pulse_ack(input bit chg);
        @(negedge clk);
        ack = 1'b1;
        if (chg) exp_q.push_back('{cyc + 1, 32'h0, 4'd0, 1'b0, 1'b0});
        @(negedge clk);
        ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        digit     = 4'h0;
        digit_key = 1'b0;
        enter_key = 1'b0;
        clear_key = 1'b0;
`ifdef OPERAND_ENTRY_BACKSPACE_EN
        back_key  = 1'b0;
`endif
        ack       = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (cur !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_state: outputs=%h, required 0", cur);
        end
        reset = 1'b0;
        @(posedge clk);
        mon_en = 1'b1;

        // Eight digits, then a ninth that must be refused, then lock.
        for (int i = 0; i < 8; i++)
            press(4'b0001, 4'(i + 1), 1'b1, seq_op[i], 4'(i + 1), (i == 7), 1'b0);
        press(4'b0001, 4'h9, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
        press(4'b0010, 4'h0, 1'b1, 32'h12345678, 4'd8, 1'b1, 1'b1);
        // Locked: digit and enter presses are ignored; ack releases.
        press(4'b0001, 4'h3, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
        press(4'b0010, 4'h0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
        pulse_ack(1'b1);
        // Enter in EMPTY is ignored.
        press(4'b0010, 4'h0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0);

        // Lock 32'hAB, stray digit while locked, then ack.
        press(4'b0001, 4'hA, 1'b1, 32'hA, 4'd1, 1'b0, 1'b0);
        press(4'b0001, 4'hB, 1'b1, 32'hAB, 4'd2, 1'b0, 1'b0);
        press(4'b0010, 4'h0, 1'b1, 32'hAB, 4'd2, 1'b0, 1'b1);
        press(4'b0001, 4'h5, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
        pulse_ack(1'b1);

        // Ack outside LOCKED is ignored.
        press(4'b0001, 4'h5, 1'b1, 32'h5, 4'd1, 1'b0, 1'b0);
        pulse_ack(1'b0);
        // Clear beats a simultaneous digit.
        press(4'b0101, 4'h9, 1'b1, 32'h0, 4'd0, 1'b0, 1'b0);
        // Enter beats a simultaneous digit.
        press(4'b0001, 4'h7, 1'b1, 32'h7, 4'd1, 1'b0, 1'b0);
        press(4'b0011, 4'h8, 1'b1, 32'h7, 4'd1, 1'b0, 1'b1);
        // Clear also releases a locked operand.
        press(4'b0100, 4'h0, 1'b1, 32'h0, 4'd0, 1'b0, 1'b0);

        // Reset mid-entry while digit_key is held: one commit 3 edges after release.
        press(4'b0001, 4'h1, 1'b1, 32'h1, 4'd1, 1'b0, 1'b0);
        press(4'b0001, 4'h2, 1'b1, 32'h12, 4'd2, 1'b0, 1'b0);
        press(4'b0001, 4'h3, 1'b1, 32'h123, 4'd3, 1'b0, 1'b0);
        @(negedge clk);
        digit     = 4'h4;
        digit_key = 1'b1;
        reset     = 1'b1;
        exp_q.push_back('{cyc + 1, 32'h0, 4'd0, 1'b0, 1'b0});
        exp_q.push_back('{cyc + 4, 32'h4, 4'd1, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        digit_key = 1'b0;
        repeat (4) @(negedge clk);

`ifdef OPERAND_ENTRY_BACKSPACE_EN
        // Backspace: A,B,C -> back -> AB; down to EMPTY; back in EMPTY ignored.
        press(4'b0100, 4'h0, 1'b1, 32'h0, 4'd0, 1'b0, 1'b0);
        press(4'b0001, 4'hA, 1'b1, 32'hA, 4'd1, 1'b0, 1'b0);
        press(4'b0001, 4'hB, 1'b1, 32'hAB, 4'd2, 1'b0, 1'b0);
        press(4'b0001, 4'hC, 1'b1, 32'hABC, 4'd3, 1'b0, 1'b0);
        press(4'b1000, 4'h0, 1'b1, 32'hAB, 4'd2, 1'b0, 1'b0);
        press(4'b1000, 4'h0, 1'b1, 32'hA, 4'd1, 1'b0, 1'b0);
        press(4'b1000, 4'h0, 1'b1, 32'h0, 4'd0, 1'b0, 1'b0);
        press(4'b1000, 4'h0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
        // Back in EMPTY: enter is ignored, a digit starts a new operand.
        press(4'b0010, 4'h0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
        press(4'b0001, 4'hD, 1'b1, 32'hD, 4'd1, 1'b0, 1'b0);
        // Backspace while locked is ignored.
        press(4'b0010, 4'h0, 1'b1, 32'hD, 4'd1, 1'b0, 1'b1);
        press(4'b1000, 4'h0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
        pulse_ack(1'b1);
`endif

        repeat (6) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected updates outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_operand_entry
